// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and its boot loader.
package data_memory_pkg;

  localparam int unsigned DMEM_ADDR_W_DEFAULT = 8;
  localparam int unsigned DMEM_DATA_W         = 32;

  typedef enum logic {
    DMEM_ST_LOAD = 1'b0,
    DMEM_ST_RUN  = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_loader.sv
// Boot-loader FSM: streams an image into the data memory over valid/ready
// and holds the core off via busy until the image is complete.
module dmem_loader
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              busy,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              wr_en_c,
  output logic [ADDR_W-1:0] wr_addr_c,
  output logic [DATA_W-1:0] wr_data_c
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  dmem_state_e       state;
  logic [ADDR_W-1:0] ptr;

  // Write-port request toward the memory array.
  assign wr_en_c   = (state == DMEM_ST_LOAD) && load_valid;
  assign wr_addr_c = ptr;
  assign wr_data_c = load_data;

  // State, pointer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DMEM_ST_LOAD;
      ptr        <= '0;
      load_count <= '0;
      busy       <= 1'b1;
      load_ready <= 1'b1;
    end else begin
      case (state)
        DMEM_ST_LOAD: begin
          if (load_valid) begin
            ptr        <= ptr + ADDR_W'(1);
            load_count <= load_count + (ADDR_W + 1)'(1);
            // Leave on an explicit last word or once the array is full.
            if (load_last || (ptr == PTR_LAST)) begin
              state      <= DMEM_ST_RUN;
              busy       <= 1'b0;
              load_ready <= 1'b0;
            end
          end
        end
        DMEM_ST_RUN: begin
          if (load_start) begin
            state      <= DMEM_ST_LOAD;
            ptr        <= '0;
            load_count <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= DMEM_ST_LOAD;
          busy       <= 1'b1;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the core's load/store port, with an optional
// boot loader enabled by defining DMEM_LOADER_EN.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       a,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              oob,
  output logic              busy,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              cpu_we_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_wa_c;
  logic [DATA_W-1:0] mem_wd_c;

  assign oob = |a[31:ADDR_W];
  assign rd  = oob ? '0 : mem[a[ADDR_W-1:0]];

`ifdef DMEM_LOADER_EN
  logic              ldr_we_c;
  logic [ADDR_W-1:0] ldr_wa_c;
  logic [DATA_W-1:0] ldr_wd_c;

  dmem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .busy       (busy),
    .load_ready (load_ready),
    .load_count (load_count),
    .wr_en_c    (ldr_we_c),
    .wr_addr_c  (ldr_wa_c),
    .wr_data_c  (ldr_wd_c)
  );

  // CPU stores only land in RUN; the loader owns the port while busy.
  assign cpu_we_c = we && !oob && !busy;
  assign mem_we_c = ldr_we_c || cpu_we_c;
  assign mem_wa_c = ldr_we_c ? ldr_wa_c : a[ADDR_W-1:0];
  assign mem_wd_c = ldr_we_c ? ldr_wd_c : wd;
`else
  logic unused_loader_c;

  assign unused_loader_c = ^{rst_n, load_start, load_valid, load_data, load_last};
  assign busy       = 1'b0;
  assign load_ready = 1'b0;
  assign load_count = '0;

  assign cpu_we_c = we && !oob;
  assign mem_we_c = cpu_we_c;
  assign mem_wa_c = a[ADDR_W-1:0];
  assign mem_wd_c = wd;
`endif

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_wa_c] <= mem_wd_c;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: per-cycle comparison against a word-level
// model plus literal expectations; adapts to DMEM_LOADER_EN.
module tb_data_memory;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef DMEM_LOADER_EN
  localparam bit LOADER_EN = 1'b1;
`else
  localparam bit LOADER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        oob;
  logic        busy;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [AW:0] load_count;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  data_memory #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .we         (we),
    .wd         (wd),
    .rd         (rd),
    .oob        (oob),
    .busy       (busy),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  // Word-level model: loading flag, words-loaded count, array image.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_load;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= LOADER_EN;
      m_cnt  <= 0;
    end else if (m_load) begin
      if (load_valid) begin
        m_mem[m_cnt % DEPTH]   <= load_data;
        m_known[m_cnt % DEPTH] <= 1'b1;
        m_cnt                  <= m_cnt + 1;
        if (load_last || m_cnt + 1 == DEPTH) m_load <= 1'b0;
      end
    end else begin
      if (we && a < DEPTH) begin
        m_mem[a % DEPTH]   <= wd;
        m_known[a % DEPTH] <= 1'b1;
      end
      if (load_start && LOADER_EN) begin
        m_load <= 1'b1;
        m_cnt  <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("oob", 32'(oob), 32'(a >= DEPTH));
      chk("busy", 32'(busy), 32'(m_load));
      chk("load_ready", 32'(load_ready), 32'(m_load));
      chk("load_count", 32'(load_count), 32'(m_cnt));
      if (a >= DEPTH) chk("rd_oob", rd, 32'h0);
      else if (m_known[a % DEPTH]) chk("rd", rd, m_mem[a % DEPTH]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] d);
    a  = addr;
    we = 1'b1;
    wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(LOADER_EN));
    chk("rst_ready", 32'(load_ready), 32'(LOADER_EN));
    chk("rst_count", 32'(load_count), 32'd0);
    #2 rst_n = 1'b1;
    tick();

`ifdef DMEM_LOADER_EN
    // Four-word boot image terminated by load_last.
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h33, 1'b0);
    load_valid = 1'b1; load_data = 32'h44; load_last = 1'b1;
    #1 chk("busy_during_last", 32'(busy), 32'd1);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("count_after_4", 32'(load_count), 32'd4);
    chk("busy_after_4", 32'(busy), 32'd0);
`else
    // No loader: its inputs are ignored and the image comes from stores.
    load_start = 1'b1; load_valid = 1'b1; load_data = 32'hFFFF; load_last = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    chk("noldr_busy", 32'(busy), 32'd0);
    chk("noldr_count", 32'(load_count), 32'd0);
    cpu_write(32'd0, 32'h11);
    cpu_write(32'd2, 32'h33);
`endif
    a = 32'd2;
    #1 chk("rd_a2", rd, 32'h33);

    // Read-during-write returns the old word.
    cpu_write(32'd5, 32'h55);
    we = 1'b1; wd = 32'hDEADBEEF;
    #1 chk("rdw_old", rd, 32'h55);
    tick();
    we = 1'b0;
    chk("rdw_new", rd, 32'hDEADBEEF);

    // Out-of-range store is dropped and must not alias onto word 0.
    a = 32'h100; we = 1'b1; wd = 32'hBAD;
    #1 chk("oob_flag", 32'(oob), 32'd1);
    chk("oob_rd", rd, 32'h0);
    tick();
    we = 1'b0; a = 32'd0;
    #1 chk("oob_no_alias", rd, 32'h11);

`ifdef DMEM_LOADER_EN
    // Same-cycle load_start and store: store commits, LOAD follows.
    a = 32'd7; we = 1'b1; wd = 32'd9; load_start = 1'b1;
    #1 chk("start_busy_pre", 32'(busy), 32'd0);
    tick();
    we = 1'b0; load_start = 1'b0;
    chk("start_busy_post", 32'(busy), 32'd1);
    chk("start_count", 32'(load_count), 32'd0);
    #1 chk("start_store", rd, 32'd9);
    cpu_write(32'd2, 32'hFFFF);
    a = 32'd2;
    #1 chk("load_store_dropped", rd, 32'h33);

    // Full-array load without load_last; extra word afterwards ignored.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i), 1'b0);
    chk("full_count", 32'(load_count), 32'd256);
    chk("full_busy", 32'(busy), 32'd0);
    push(32'hBAD, 1'b0);
    a = 32'd0;
    #1 chk("full_word0", rd, 32'h1000);
    a = 32'd255;
    #1 chk("full_word255", rd, 32'h10FF);

    // Reset in the middle of a reload restarts pointer and count.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    push(32'hA0, 1'b0);
    push(32'hA1, 1'b0);
    chk("mid_count", 32'(load_count), 32'd2);
    rst_n = 1'b0;
    #2 chk("mid_rst_count", 32'(load_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    push(32'hB0, 1'b1);
    chk("reload_count", 32'(load_count), 32'd1);
    a = 32'd0;
    #1 chk("reload_word0", rd, 32'hB0);
    a = 32'd1;
    #1 chk("reload_word1", rd, 32'hA1);
`else
    load_start = 1'b1; load_valid = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    chk("noldr_start_ignored", 32'(busy), 32'd0);
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
